// File: rtl/csr_trap_ctrl.sv
// Sequencer for RISC-V SYSTEM instructions: Zicsr read/modify/write and ecall/mret.
// One instruction at a time; results are held in DONE until the consumer takes them.
module csr_trap_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  output logic [11:0] csr_raddr,
  input  logic [31:0] csr_rdata,
  output logic        csr_wen,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        ecall,
  output logic        mret,
  output logic [31:0] trap_pc,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        rd_wen,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_wdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        illegal
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    TRAP  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
  localparam logic [11:0] IMM_ECALL  = 12'h000;
  localparam logic [11:0] IMM_MRET   = 12'h302;

  state_e      state_q, state_d;
  logic [31:7] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] old_q, old_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        illegal_q, illegal_d;
  logic        mret_q, mret_d;

  logic [2:0]  in_funct3_s;
  logic        in_trap_ok_s;
  logic [31:0] src_s;
  logic [31:0] new_val_s;
  logic        write_needed_s;
  logic        is_csr_s;
  logic        is_trap_s;

  assign in_funct3_s  = in_inst[14:12];
  assign in_trap_ok_s = (in_inst[19:15] == 5'd0) && (in_inst[11:7] == 5'd0) &&
                        ((in_inst[31:20] == IMM_ECALL) || (in_inst[31:20] == IMM_MRET));

  // Operand and new CSR value from the latched instruction and the captured old value.
  always_comb begin
    src_s = inst_q[14] ? {27'd0, inst_q[19:15]} : rs1_q;
    case (inst_q[13:12])
      2'b01:   new_val_s = src_s;
      2'b10:   new_val_s = old_q | src_s;
      2'b11:   new_val_s = old_q & ~src_s;
      default: new_val_s = src_s;
    endcase
    write_needed_s = (inst_q[13:12] == 2'b01) || (inst_q[19:15] != 5'd0);
    is_csr_s       = !illegal_q && (inst_q[14:12] != 3'b000);
    is_trap_s      = !illegal_q && (inst_q[14:12] == 3'b000);
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d       = state_q;
    inst_d        = inst_q;
    pc_d          = pc_q;
    rs1_d         = rs1_q;
    old_d         = old_q;
    redirect_pc_d = redirect_pc_q;
    illegal_d     = illegal_q;
    mret_d        = mret_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          inst_d        = in_inst[31:7];
          pc_d          = in_pc;
          rs1_d         = in_rs1;
          old_d         = 32'd0;
          redirect_pc_d = 32'd0;
          illegal_d     = 1'b0;
          mret_d        = 1'b0;
          if (in_inst[6:0] != OPC_SYSTEM) begin
            illegal_d = 1'b1;
            state_d   = DONE;
          end else begin
            case (in_funct3_s)
              3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111: state_d = READ;
              3'b000: begin
                if (in_trap_ok_s) begin
                  mret_d  = (in_inst[31:20] == IMM_MRET);
                  state_d = TRAP;
                end else begin
                  illegal_d = 1'b1;
                  state_d   = DONE;
                end
              end
              default: begin
                illegal_d = 1'b1;
                state_d   = DONE;
              end
            endcase
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        old_d   = csr_rdata;
        state_d = write_needed_s ? WRITE : DONE;
      end
      WRITE: state_d = DONE;
      TRAP: begin
        redirect_pc_d = mret_q ? mepc_in : mtvec_in;
        state_d       = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      inst_q        <= '0;
      pc_q          <= 32'd0;
      rs1_q         <= 32'd0;
      old_q         <= 32'd0;
      redirect_pc_q <= 32'd0;
      illegal_q     <= 1'b0;
      mret_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      inst_q        <= inst_d;
      pc_q          <= pc_d;
      rs1_q         <= rs1_d;
      old_q         <= old_d;
      redirect_pc_q <= redirect_pc_d;
      illegal_q     <= illegal_d;
      mret_q        <= mret_d;
    end
  end

  // Outputs decoded from the current state; everything idles at zero.
  always_comb begin
    in_ready    = (state_q == IDLE) && !reset;
    csr_raddr   = 12'd0;
    csr_wen     = 1'b0;
    csr_waddr   = 12'd0;
    csr_wdata   = 32'd0;
    ecall       = 1'b0;
    mret        = 1'b0;
    trap_pc     = 32'd0;
    out_valid   = 1'b0;
    rd_wen      = 1'b0;
    rd_addr     = 5'd0;
    rd_wdata    = 32'd0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    illegal     = 1'b0;
    case (state_q)
      READ: csr_raddr = inst_q[31:20];
      WRITE: begin
        csr_wen   = 1'b1;
        csr_waddr = inst_q[31:20];
        csr_wdata = new_val_s;
      end
      TRAP: begin
        ecall   = !mret_q;
        mret    = mret_q;
        trap_pc = pc_q;
      end
      DONE: begin
        out_valid = 1'b1;
        illegal   = illegal_q;
        rd_addr   = inst_q[11:7];
        rd_wen    = is_csr_s && (inst_q[11:7] != 5'd0);
        rd_wdata  = rd_wen ? old_q : 32'd0;
        redirect  = is_trap_s;
        if (is_trap_s) begin
          redirect_pc = redirect_pc_q;
        end else begin
          redirect_pc = 32'd0;
        end
      end
      default: in_ready = in_ready;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl with a tiny CSR file model driving csr_rdata,
// mtvec_in and mepc_in, and a monitor that applies and counts CSR writes.
module tb_csr_trap_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst, in_pc, in_rs1;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        ecall, mret;
  logic [31:0] trap_pc, mtvec_in, mepc_in;
  logic        out_valid, out_ready;
  logic        rd_wen;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mtvec_m = 32'd0;
  logic [31:0] mstatus_m = 32'h0000188A;
  logic [31:0] mepc_m = 32'h80000040;
  int          wr_count = 0;
  int          wr_base;
  int          ov_seen;

  localparam logic [6:0] OP = 7'b1110011;

  csr_trap_ctrl dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_rs1(in_rs1),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .ecall(ecall), .mret(mret), .trap_pc(trap_pc),
    .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .illegal(illegal)
  );

  always #5 clock = ~clock;

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_raddr)
      12'h305: csr_rdata = mtvec_m;
      12'h300: csr_rdata = mstatus_m;
      12'hF11: csr_rdata = 32'h79737978;
      12'h341: csr_rdata = mepc_m;
      default: csr_rdata = 32'd0;
    endcase
  end
  assign mtvec_in = mtvec_m;
  assign mepc_in  = mepc_m;

  always @(posedge clock) begin
    if (csr_wen) begin
      wr_count <= wr_count + 1;
      if (csr_waddr == 12'h305) mtvec_m <= csr_wdata;
      if (csr_waddr == 12'h300) mstatus_m <= csr_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rs1);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    in_rs1   = rs1;
    step();
    in_valid = 1'b0;
    in_inst  = 32'd0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0; in_rs1 = 32'd0;
    out_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_strobes", {29'd0, csr_wen, ecall, mret}, 32'd0);
    chk("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // csrrw x5, mtvec, rs1
    wr_base = wr_count;
    issue({12'h305, 5'd10, 3'b001, 5'd5, OP}, 32'h80000000, 32'h80000100);
    chk("rw_read_addr", {20'd0, csr_raddr}, 32'h305);
    chk("rw_c1_wen", {31'd0, csr_wen}, 32'd0);
    step();
    chk("rw_wen", {31'd0, csr_wen}, 32'd1);
    chk("rw_waddr", {20'd0, csr_waddr}, 32'h305);
    chk("rw_wdata", csr_wdata, 32'h80000100);
    chk("rw_c2_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("rw_out_valid", {31'd0, out_valid}, 32'd1);
    chk("rw_rd_wen", {31'd0, rd_wen}, 32'd1);
    chk("rw_rd_addr", {27'd0, rd_addr}, 32'd5);
    chk("rw_rd_wdata", rd_wdata, 32'd0);
    chk("rw_wr_count", wr_count - wr_base, 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("rw_back_idle", {31'd0, in_ready}, 32'd1);

    // csrrs x6, mvendorid, x0: read only
    wr_base = wr_count;
    issue({12'hF11, 5'd0, 3'b010, 5'd6, OP}, 32'h80000004, 32'd0);
    chk("rs_c1_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("rs_out_valid", {31'd0, out_valid}, 32'd1);
    chk("rs_rd_wdata", rd_wdata, 32'h79737978);
    chk("rs_rd_addr", {27'd0, rd_addr}, 32'd6);
    chk("rs_no_write", wr_count - wr_base, 32'd0);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // csrrci x0, mstatus, 8
    issue({12'h300, 5'd8, 3'b111, 5'd0, OP}, 32'h80000008, 32'hFFFFFFFF);
    step();
    chk("rci_wen", {31'd0, csr_wen}, 32'd1);
    chk("rci_wdata", csr_wdata, 32'h00001882);
    step();
    chk("rci_out_valid", {31'd0, out_valid}, 32'd1);
    chk("rci_rd_wen", {31'd0, rd_wen}, 32'd0);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // ecall
    issue(32'h00000073, 32'h80000040, 32'd0);
    chk("ecall_strobe", {30'd0, ecall, mret}, 32'd2);
    chk("ecall_trap_pc", trap_pc, 32'h80000040);
    chk("ecall_no_wen", {31'd0, csr_wen}, 32'd0);
    step();
    chk("ecall_done", {30'd0, out_valid, redirect}, 32'd3);
    chk("ecall_redirect_pc", redirect_pc, 32'h80000100);
    chk("ecall_strobe_off", {30'd0, ecall, mret}, 32'd0);
    chk("ecall_rd_wen", {31'd0, rd_wen}, 32'd0);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // mret
    issue(32'h30200073, 32'h80000200, 32'd0);
    chk("mret_strobe", {30'd0, ecall, mret}, 32'd1);
    step();
    chk("mret_redirect", {31'd0, redirect}, 32'd1);
    chk("mret_redirect_pc", redirect_pc, 32'h80000040);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // csrrs x7, mstatus, rs1=0x10 with a stalled consumer
    wr_base = wr_count;
    issue({12'h300, 5'd3, 3'b010, 5'd7, OP}, 32'h8000000C, 32'h00000010);
    step();
    chk("stall_wdata", csr_wdata, 32'h00001892);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_rd_wdata", rd_wdata, 32'h00001882);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_wen", {31'd0, csr_wen}, 32'd0);
      step();
    end
    chk("stall_single_write", wr_count - wr_base, 32'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // funct3 = 100 is illegal
    wr_base = wr_count;
    issue({12'h300, 5'd0, 3'b100, 5'd0, OP}, 32'h80000010, 32'd0);
    chk("ill_out_valid", {31'd0, out_valid}, 32'd1);
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_side_effects", {28'd0, rd_wen, redirect, ecall, mret}, 32'd0);
    chk("ill_no_write", wr_count - wr_base, 32'd0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("ill_idle", {31'd0, illegal}, 32'd0);

    // reset during WRITE
    issue({12'h305, 5'd1, 3'b001, 5'd5, OP}, 32'h80000014, 32'h12345678);
    step();
    chk("abort_in_write", {31'd0, csr_wen}, 32'd1);
    reset = 1'b1;
    step();
    chk("abort_wen", {31'd0, csr_wen}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready_rst", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    ov_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) ov_seen++;
      step();
    end
    chk("abort_no_out_valid", ov_seen, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
